// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with a show-ahead FIFO of received words.
// Each FIFO entry is {frame_err, parity_err, data}; errored words are kept and tagged.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          baud_tick,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_parity_err,
   output logic                          rd_frame_err,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          break_det
);

   localparam int CW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int NW  = PW + 1;
   localparam int EW  = DATA_BITS + 2;
   localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   rx_meta;
   logic                   rx_s;
   logic [CW-1:0]          ctr;
   logic [BW-1:0]          bit_idx;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_err;
   logic                   frm_err;

   logic                   bit_pt;
   logic                   last_data;
   logic                   last_stop;
   logic                   push;
   logic                   word_fe;
   logic                   word_break;

   logic [EW-1:0]          mem [FIFO_DEPTH];
   logic [EW-1:0]          held;
   logic [EW-1:0]          head;
   logic [PW-1:0]          rd_ptr;
   logic [PW-1:0]          wr_ptr;
   logic                   full;
   logic                   pop;
   logic                   wr_ok;

   // The line is asynchronous; it idles high so the synchroniser resets to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (baud_tick) begin
         case (state)
            S_IDLE:   if (!rx_s) state_next = S_START;
            S_START:  if (ctr == HALF) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (ctr == LAST && last_data)
                         state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (ctr == LAST) state_next = S_STOP;
            S_STOP:   if (ctr == LAST && last_stop) state_next = S_IDLE;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bit_pt     = baud_tick && (ctr == LAST);
      last_data  = (bit_idx == BW'(DATA_BITS - 1));
      last_stop  = (bit_idx == BW'(STOP_BITS - 1));
      push       = bit_pt && (state == S_STOP) && last_stop;
      word_fe    = frm_err | ~rx_s;
      word_break = (shreg == '0) && word_fe;
   end

   // Bit timing and frame assembly; ctr restarts at 0 after every mid-bit sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else if (baud_tick) begin
         case (state)
            S_IDLE: begin
               ctr     <= '0;
               bit_idx <= '0;
               par_err <= 1'b0;
               frm_err <= 1'b0;
            end
            S_START: begin
               if (ctr == HALF) begin
                  ctr     <= '0;
                  bit_idx <= '0;
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end
            S_DATA: begin
               if (ctr == LAST) begin
                  ctr     <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= last_data ? '0 : bit_idx + BW'(1);
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end
            S_PARITY: begin
               if (ctr == LAST) begin
                  ctr     <= '0;
                  par_err <= ((^shreg) ^ rx_s) != (PARITY == 1);
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end
            S_STOP: begin
               if (ctr == LAST) begin
                  ctr     <= '0;
                  bit_idx <= bit_idx + BW'(1);
                  if (!rx_s) frm_err <= 1'b1;
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end
            default: ctr <= '0;
         endcase
      end
   end

   assign rd_valid = (fifo_count != '0);
   assign full     = (fifo_count == NW'(FIFO_DEPTH));
   assign pop      = rd_en && rd_valid;
   assign wr_ok    = push && (!full || pop);
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= {word_fe, par_err, shreg};
   end

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         overrun   <= push && full && !pop;
         break_det <= push && word_break;
         if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         case ({wr_ok, pop})
            2'b10:   fifo_count <= fifo_count + NW'(1);
            2'b01:   fifo_count <= fifo_count - NW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Once the FIFO drains, the read port keeps showing the last head it presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           held <= '0;
      else if (rd_valid) held <= head;
   end

   assign {rd_frame_err, rd_parity_err, rd_data} = rd_valid ? head : held;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo (8 data bits, even parity, 1 stop bit, depth 4).
// Frames are built bit by bit and the expected FIFO contents are kept as a queue of words.
module tb_uart_rx_fifo;

   localparam int DB       = 8;
   localparam int OS       = 8;
   localparam int PAR      = 2;
   localparam int SB       = 1;
   localparam int DEPTH    = 4;
   localparam int TICK_DIV = 4;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       baud_tick = 1'b0;
   logic                       rx = 1'b1;
   logic                       rd_en = 1'b0;
   logic [DB-1:0]              rd_data;
   logic                       rd_parity_err;
   logic                       rd_frame_err;
   logic                       rd_valid;
   logic [$clog2(DEPTH):0]     fifo_count;
   logic                       overrun;
   logic                       break_det;

   typedef struct {
      logic [DB-1:0] data;
      logic          pe;
      logic          fe;
   } entry_t;

   entry_t        model_q[$];
   logic [DB-1:0] last_data = '0;
   logic          last_pe = 1'b0;
   logic          last_fe = 1'b0;
   int            checks = 0;
   int            errors = 0;
   int            ovr_seen = 0;
   int            brk_seen = 0;
   int            ovr_exp = 0;
   int            brk_exp = 0;
   int            tick_cnt = 0;

   uart_rx_fifo #(
      .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx), .rd_en(rd_en),
      .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
      .rd_valid(rd_valid), .fifo_count(fifo_count), .overrun(overrun), .break_det(break_det)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tick_cnt  = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
      baud_tick = (tick_cnt == TICK_DIV - 1);
   end

   always @(negedge clk) begin
      if (rst) begin
         ovr_seen = 0;
         brk_seen = 0;
      end else begin
         if (overrun)   ovr_seen++;
         if (break_det) brk_seen++;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitTick();
      do @(posedge clk); while (baud_tick !== 1'b1);
      #1;
   endtask

   task automatic checkHead(input string tag);
      checkOutput({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
      checkOutput({tag, "_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         checkOutput({tag, "_data"}, 32'(rd_data), 32'(model_q[0].data));
         checkOutput({tag, "_pe"}, 32'(rd_parity_err), 32'(model_q[0].pe));
         checkOutput({tag, "_fe"}, 32'(rd_frame_err), 32'(model_q[0].fe));
      end else begin
         checkOutput({tag, "_held"}, 32'({rd_frame_err, rd_parity_err, rd_data}),
                     32'({last_fe, last_pe, last_data}));
      end
   endtask

   task automatic checkFlags(input string tag);
      checkOutput({tag, "_overruns"}, 32'(ovr_seen), 32'(ovr_exp));
      checkOutput({tag, "_breaks"}, 32'(brk_seen), 32'(brk_exp));
   endtask

   task automatic modelPop();
      if (model_q.size() != 0) begin
         last_data = model_q[0].data;
         last_pe   = model_q[0].pe;
         last_fe   = model_q[0].fe;
         void'(model_q.pop_front());
      end
   endtask

   task automatic modelReset();
      model_q.delete();
      last_data = '0;
      last_pe   = 1'b0;
      last_fe   = 1'b0;
      ovr_exp   = 0;
      brk_exp   = 0;
   endtask

   task automatic readEntries(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         checkHead(tag);
         rd_en = 1'b1;
         @(posedge clk);
         #1;
         rd_en = 1'b0;
         modelPop();
      end
      checkHead({tag, "_after"});
   endtask

   // Sends one frame; abort_bit >= 0 resets the DUT halfway through that frame bit.
   task automatic applyStimulus(input logic [DB-1:0] data, input bit par_bad, input bit stop_bad,
                                input bit pop_at_push, input int abort_bit);
      logic   bits[$];
      logic   pbit;
      entry_t e;
      int     ones;
      bits.push_back(1'b0);
      for (int j = 0; j < DB; j++) bits.push_back(data[j]);
      pbit = 1'b0;
      if (PAR != 0) begin
         pbit = ((PAR == 2) ? ^data : ~^data) ^ par_bad;
         bits.push_back(pbit);
      end
      for (int s = 0; s < SB; s++) bits.push_back(!(stop_bad && s == 0));
      waitTick();
      for (int j = 0; j < bits.size(); j++) begin
         rx = bits[j];
         if (j == abort_bit) begin
            repeat (OS / 2) waitTick();
            rst = 1'b1;
            rx  = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            modelReset();
            return;
         end
         if (j == bits.size() - 1 && pop_at_push) begin
            repeat (OS / 2) waitTick();
            do begin
               @(negedge clk);
               #1;
            end while (baud_tick !== 1'b1);
            checkHead("prepop");
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            modelPop();
            repeat (OS - OS / 2 - 1) waitTick();
         end else begin
            repeat (OS) waitTick();
         end
      end
      rx = 1'b1;
      if (stop_bad) repeat (OS) waitTick();
      ones   = $countones(data) + ((PAR != 0) ? int'(pbit) : 0);
      e.data = data;
      e.pe   = (PAR == 0) ? 1'b0 : (PAR == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      e.fe   = stop_bad;
      if (data == '0 && stop_bad) brk_exp++;
      if (model_q.size() < DEPTH) model_q.push_back(e);
      else                        ovr_exp++;
   endtask

   initial begin
      logic [DB-1:0] d;
      logic [DB-1:0] burst[5];

      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      checkHead("reset");
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      checkOutput("reset_break", 32'(break_det), 32'd0);

      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, -1);
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      checkHead("two_words");
      readEntries(2, "drain_two");

      applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, -1);
      applyStimulus(8'h07, 1'b0, 1'b0, 1'b0, -1);
      checkHead("parity");
      readEntries(2, "drain_parity");

      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, -1);
      checkHead("break");
      checkFlags("break");
      readEntries(2, "drain_break");

      waitTick();
      rx = 1'b0;
      repeat (2) waitTick();
      rx = 1'b1;
      repeat (OS * 2) waitTick();
      checkHead("false_start");
      applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, -1);
      checkHead("after_false_start");
      readEntries(1, "drain_fs");

      for (int i = 0; i < 5; i++) begin
         burst[i] = 8'($urandom);
         applyStimulus(burst[i], 1'b0, 1'b0, 1'b0, -1);
      end
      checkHead("overrun");
      checkOutput("overrun_head", 32'(rd_data), 32'(burst[0]));
      checkFlags("overrun");
      readEntries(DEPTH, "drain_overrun");

      for (int i = 0; i < 5; i++) begin
         burst[i] = 8'($urandom);
         applyStimulus(burst[i], 1'b0, 1'b0, (i == 4), -1);
      end
      checkHead("full_pop_push");
      checkFlags("full_pop_push");
      readEntries(DEPTH - 1, "drain_fpp");
      checkOutput("fpp_last", 32'(rd_data), 32'(burst[4]));
      readEntries(1, "drain_fpp_end");

      applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, -1);
      applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 4);
      checkHead("abort");
      checkOutput("abort_overrun", 32'(overrun), 32'd0);
      checkOutput("abort_break", 32'(break_det), 32'd0);
      applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, -1);
      checkHead("after_abort");
      readEntries(1, "drain_abort");

      for (int n = 0; n < 40; n++) begin
         d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 4) == 0), -1);
         checkHead("rand");
         checkFlags("rand");
         if ($urandom_range(0, 1) == 1) readEntries($urandom_range(0, 3), "rand_read");
      end
      readEntries(DEPTH + 1, "final_drain");
      checkFlags("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
